// File: rtl/branch_predictor_if.sv
// Fetch/resolve bundle between the fetch stage, the execute stage and branch_predictor.
interface branch_predictor_if #(
  parameter int PC_W = 8
);
  logic            memory_stall;
  logic [PC_W-1:0] fetch_pc;
  logic            pred_taken;
  logic [PC_W-1:0] pred_next_pc;
  logic            res_valid;
  logic [PC_W-1:0] res_pc;
  logic [PC_W-1:0] res_target;
  logic            res_taken;
  logic            res_prev_taken;
  logic            flush;
  logic [PC_W-1:0] redirect_pc;

  modport master (
    output memory_stall, fetch_pc, res_valid, res_pc, res_target, res_taken, res_prev_taken,
    input  pred_taken, pred_next_pc, flush, redirect_pc
  );

  modport slave (
    input  memory_stall, fetch_pc, res_valid, res_pc, res_target, res_taken, res_prev_taken,
    output pred_taken, pred_next_pc, flush, redirect_pc
  );
endinterface

// File: rtl/branch_predictor.sv
// Fetch-side predictor: 2-bit BHT plus direct-mapped BTB, trained from execute-stage resolutions.
// Optional BP_PERF_CNT_EN adds saturating resolution/mispredict counters.
module branch_predictor #(
  parameter int IDX_W = 4,
  parameter int PC_W  = 8
) (
  input  logic clk,
  input  logic rst,
  branch_predictor_if.slave bus
`ifdef BP_PERF_CNT_EN
  ,
  output logic [15:0] perf_branches,
  output logic [15:0] perf_mispredicts
`endif
);
  localparam int unsigned DEPTH = 1 << IDX_W;
  localparam int TAG_W = PC_W - IDX_W - 2;

  logic [1:0]       cnt      [DEPTH];
  logic [DEPTH-1:0] valid;
  logic [TAG_W-1:0] tag_q    [DEPTH];
  logic [PC_W-1:0]  target_q [DEPTH];

  logic [IDX_W-1:0] f_idx, r_idx;
  logic [TAG_W-1:0] f_tag, r_tag;
  logic             hit, taken_pred, accept, mispredict, r_miss;
  logic [1:0]       next_cnt;

  always_comb begin
    f_idx = bus.fetch_pc[IDX_W+1:2];
    f_tag = bus.fetch_pc[PC_W-1:IDX_W+2];
    r_idx = bus.res_pc[IDX_W+1:2];
    r_tag = bus.res_pc[PC_W-1:IDX_W+2];

    // Reads see registered state only, so a same-cycle update shows up next cycle.
    hit        = valid[f_idx] && (tag_q[f_idx] == f_tag);
    taken_pred = !rst && hit && cnt[f_idx][1];
    bus.pred_taken   = taken_pred;
    bus.pred_next_pc = taken_pred ? target_q[f_idx] : bus.fetch_pc + PC_W'(4);

    accept     = bus.res_valid && !bus.memory_stall && !rst;
    mispredict = accept && (bus.res_taken != bus.res_prev_taken);
    bus.flush       = mispredict;
    bus.redirect_pc = mispredict ? bus.res_target : '0;

    // An invalid entry counts as a miss: a taken branch allocates it fresh at weakly-taken.
    r_miss   = !valid[r_idx] || (tag_q[r_idx] != r_tag);
    next_cnt = cnt[r_idx];
    if (bus.res_taken) begin
      if (r_miss)
        next_cnt = 2'b10;
      else if (cnt[r_idx] != 2'b11)
        next_cnt = cnt[r_idx] + 2'b01;
    end else if (cnt[r_idx] != 2'b00) begin
      next_cnt = cnt[r_idx] - 2'b01;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        cnt[i]      <= 2'b01;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
      end
    end else if (accept) begin
      cnt[r_idx] <= next_cnt;
      if (bus.res_taken) begin
        valid[r_idx]    <= 1'b1;
        tag_q[r_idx]    <= r_tag;
        target_q[r_idx] <= bus.res_target;
      end
    end
  end

`ifdef BP_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_branches    <= '0;
      perf_mispredicts <= '0;
    end else begin
      if (accept && perf_branches != '1)
        perf_branches <= perf_branches + 16'd1;
      if (mispredict && perf_mispredicts != '1)
        perf_mispredicts <= perf_mispredicts + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: directed scenarios then random traffic vs. a table model.
module tb_branch_predictor;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  branch_predictor_if #(.PC_W(8)) bp ();

`ifdef BP_PERF_CNT_EN
  logic [15:0] perf_branches, perf_mispredicts;
`endif

  branch_predictor #(.IDX_W(4), .PC_W(8)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bp)
`ifdef BP_PERF_CNT_EN
    ,
    .perf_branches(perf_branches),
    .perf_mispredicts(perf_mispredicts)
`endif
  );

  int nvec = 0;
  int nerr = 0;

  // Reference model: plain integer tables indexed by word address.
  int m_cnt [16];
  bit m_vld [16];
  int m_tag [16];
  int m_tgt [16];
  int m_br, m_mis;

  logic       last_pt, last_fl;
  logic [7:0] last_npc, last_rd;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    for (int i = 0; i < 16; i++) begin
      m_cnt[i] = 1; m_vld[i] = 0; m_tag[i] = 0; m_tgt[i] = 0;
    end
    m_br = 0; m_mis = 0;
  endtask

  // One cycle: drive, compare combinational outputs mid-cycle, advance model at the edge.
  task automatic step(input logic r, input logic ms, input logic [7:0] fpc, input logic rv,
                      input logic [7:0] rpc, input logic [7:0] rtgt, input logic rt, input logic rpt);
    int fi, ft, ri, rtag, e_pt, e_npc, e_fl, e_rd;
    rst = r; bp.memory_stall = ms; bp.fetch_pc = fpc; bp.res_valid = rv;
    bp.res_pc = rpc; bp.res_target = rtgt; bp.res_taken = rt; bp.res_prev_taken = rpt;
    fi = (int'(fpc) / 4) % 16;  ft = int'(fpc) / 64;
    ri = (int'(rpc) / 4) % 16;  rtag = int'(rpc) / 64;
    e_pt  = (!r && m_vld[fi] && m_tag[fi] == ft && m_cnt[fi] >= 2) ? 1 : 0;
    e_npc = (e_pt != 0) ? m_tgt[fi] : (int'(fpc) + 4) % 256;
    e_fl  = (!r && rv && !ms && rt != rpt) ? 1 : 0;
    e_rd  = (e_fl != 0) ? int'(rtgt) : 0;
    @(negedge clk);
    check("pred_taken", 32'(bp.pred_taken), 32'(e_pt));
    check("pred_next_pc", 32'(bp.pred_next_pc), 32'(e_npc));
    check("flush", 32'(bp.flush), 32'(e_fl));
    check("redirect_pc", 32'(bp.redirect_pc), 32'(e_rd));
`ifdef BP_PERF_CNT_EN
    check("perf_branches", 32'(perf_branches), 32'(m_br));
    check("perf_mispredicts", 32'(perf_mispredicts), 32'(m_mis));
`endif
    last_pt = bp.pred_taken; last_npc = bp.pred_next_pc;
    last_fl = bp.flush;      last_rd = bp.redirect_pc;
    @(posedge clk);
    if (r) begin
      m_reset();
    end else if (rv && !ms) begin
      if (rt) begin
        if (!m_vld[ri] || m_tag[ri] != rtag) m_cnt[ri] = 2;
        else if (m_cnt[ri] < 3) m_cnt[ri]++;
        m_vld[ri] = 1; m_tag[ri] = rtag; m_tgt[ri] = int'(rtgt);
      end else if (m_cnt[ri] > 0) begin
        m_cnt[ri]--;
      end
      if (m_br < 65535) m_br++;
      if (e_fl != 0 && m_mis < 65535) m_mis++;
    end
    #1;
  endtask

  task automatic fetch(input logic [7:0] pc);
    step(1'b0, 1'b0, pc, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic resolve(input logic [7:0] fpc, input logic [7:0] rpc, input logic [7:0] tgt,
                         input logic rt, input logic rpt, input logic ms);
    step(1'b0, ms, fpc, 1'b1, rpc, tgt, rt, rpt);
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, 8'h10, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    check("reset_pred_taken", 32'(last_pt), 32'd0);
    check("reset_next_pc", 32'(last_npc), 32'h14);
    step(1'b1, 1'b0, 8'h10, 1'b1, 8'h10, 8'h40, 1'b1, 1'b0);
    check("reset_flush", 32'(last_fl), 32'd0);
  endtask

  initial begin
    bp.memory_stall = 0; bp.fetch_pc = 0; bp.res_valid = 0; bp.res_pc = 0;
    bp.res_target = 0; bp.res_taken = 0; bp.res_prev_taken = 0;
    m_reset();
    @(posedge clk); #1;
    do_reset();

    fetch(8'h10);
    check("first_pred", 32'(last_pt), 32'd0);
    check("first_next", 32'(last_npc), 32'h14);
    check("first_flush", 32'(last_fl), 32'd0);
    resolve(8'h10, 8'h10, 8'h40, 1'b1, 1'b0, 1'b0);
    check("train_flush", 32'(last_fl), 32'd1);
    check("train_redirect", 32'(last_rd), 32'h40);
    check("train_same_cycle_old", 32'(last_pt), 32'd0);
    fetch(8'h10);
    check("trained_pred", 32'(last_pt), 32'd1);
    check("trained_next", 32'(last_npc), 32'h40);

    repeat (3) resolve(8'h10, 8'h10, 8'h40, 1'b1, 1'b1, 1'b0);
    fetch(8'h10);
    check("sat_pred", 32'(last_pt), 32'd1);
    resolve(8'h10, 8'h10, 8'h14, 1'b0, 1'b1, 1'b0);
    fetch(8'h10);
    check("cnt10_pred", 32'(last_pt), 32'd1);
    resolve(8'h10, 8'h10, 8'h14, 1'b0, 1'b1, 1'b0);
    fetch(8'h10);
    check("cnt01_pred", 32'(last_pt), 32'd0);
    check("cnt01_next", 32'(last_npc), 32'h14);

    do_reset();
    resolve(8'h10, 8'h10, 8'h40, 1'b1, 1'b0, 1'b1);
    check("stall_flush", 32'(last_fl), 32'd0);
    check("stall_redirect", 32'(last_rd), 32'd0);
    fetch(8'h10);
    check("stall_no_train", 32'(last_pt), 32'd0);

    resolve(8'h10, 8'h10, 8'h40, 1'b1, 1'b0, 1'b0);
    fetch(8'h50);
    check("alias_miss_pred", 32'(last_pt), 32'd0);
    check("alias_miss_next", 32'(last_npc), 32'h54);
    resolve(8'h50, 8'h50, 8'h80, 1'b1, 1'b0, 1'b0);
    fetch(8'h50);
    check("alias_new_next", 32'(last_npc), 32'h80);
    fetch(8'h10);
    check("alias_evicted_pred", 32'(last_pt), 32'd0);
    check("alias_evicted_next", 32'(last_npc), 32'h14);

    fetch(8'hFC);
    check("wrap_next", 32'(last_npc), 32'h00);
    resolve(8'h50, 8'h50, 8'h54, 1'b0, 1'b1, 1'b0);
    check("same_cycle_old", 32'(last_pt), 32'd1);
    fetch(8'h50);
    check("same_cycle_new", 32'(last_pt), 32'd0);
    check("same_cycle_new_next", 32'(last_npc), 32'h54);

    // Random traffic over a few aliasing PCs so hits, replacements and saturation all recur.
    for (int n = 0; n < 3000; n++) begin
      logic [7:0] fpc, rpc, tgt;
      fpc = 8'(($urandom_range(0, 7) * 4) + ($urandom_range(0, 1) * 64));
      rpc = 8'(($urandom_range(0, 7) * 4) + ($urandom_range(0, 1) * 64));
      if ($urandom_range(0, 9) == 0) fpc = 8'($urandom);
      tgt = 8'($urandom) & 8'hFC;
      step($urandom_range(0, 199) == 0, $urandom_range(0, 4) == 0, fpc,
           $urandom_range(0, 9) < 7, rpc, tgt, 1'($urandom), 1'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
